// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// the memory stage. Data requests win arbitration, but a fetch that has lost
// STARVE_MAX consecutive contested arbitrations wins the next one.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IReqF, PCF, IFlushF         fetch request, address, response discard
//   InstrF, IReadyF             fetched word and one-cycle completion pulse
//   DReqM, MemWriteM, ALUOutM,
//   WriteDataM                  data request, store select, address, data
//   ReadDataM, DReadyM          load data and one-cycle completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                   registered memory request bus
//   mem_rdata, mem_ack          memory read data and completion
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReqF,
    input  logic [AW-1:0] PCF,
    input  logic          IFlushF,
    output logic [DW-1:0] InstrF,
    output logic          IReadyF,
    input  logic          DReqM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          DReadyM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int unsigned SCW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic            r_flush,      w_flush_nxt;
    logic [SCW-1:0]  r_starve_cnt, w_starve_nxt;
    logic            r_mem_req,    w_mem_req_nxt;
    logic            r_mem_we,     w_mem_we_nxt;
    logic [AW-1:0]   r_mem_addr,   w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
    logic [DW-1:0]   r_instr,      w_instr_nxt;
    logic            r_iready,     w_iready_nxt;
    logic [DW-1:0]   r_rdata,      w_rdata_nxt;
    logic            r_dready,     w_dready_nxt;

    logic            w_win_d;
    logic            w_ack;
    logic            w_starve_hit;

    // Fetch is owed the grant once it has lost STARVE_MAX contested rounds
    assign w_starve_hit = (r_starve_cnt >= SCW'(STARVE_MAX));
    assign w_win_d      = DReqM && (!IReqF || !w_starve_hit);
    assign w_ack        = mem_ack && r_mem_req;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_flush      <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_instr      <= '0;
            r_iready     <= 1'b0;
            r_rdata      <= '0;
            r_dready     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush      <= w_flush_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_instr      <= w_instr_nxt;
            r_iready     <= w_iready_nxt;
            r_rdata      <= w_rdata_nxt;
            r_dready     <= w_dready_nxt;
        end
    end

    // Next-state, arbitration and response capture
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_nxt     = r_flush;
        w_starve_nxt    = r_starve_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_instr_nxt     = r_instr;
        w_rdata_nxt     = r_rdata;
        w_iready_nxt    = 1'b0;
        w_dready_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (IReqF || DReqM) begin
                    w_mem_req_nxt = 1'b1;
                    if (w_win_d) begin
                        w_state_nxt    = BUSY_D;
                        w_mem_addr_nxt = ALUOutM;
                        w_mem_we_nxt   = MemWriteM;
                        if (MemWriteM) begin
                            w_mem_wdata_nxt = WriteDataM;
                        end
                        // Only a contested loss counts against fetch
                        if (IReqF && !w_starve_hit) begin
                            w_starve_nxt = r_starve_cnt + SCW'(1);
                        end
                    end else begin
                        w_state_nxt    = BUSY_I;
                        w_mem_addr_nxt = PCF;
                        w_mem_we_nxt   = 1'b0;
                        w_starve_nxt   = '0;
                        w_flush_nxt    = r_flush || IFlushF;
                    end
                end
            end
            BUSY_I: begin
                if (IFlushF) begin
                    w_flush_nxt = 1'b1;
                end
                if (w_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_instr_nxt   = mem_rdata;
                    // A flushed fetch completes on the bus but is not reported
                    w_iready_nxt  = !(r_flush || IFlushF);
                    w_state_nxt   = RESP;
                end
            end
            BUSY_D: begin
                if (w_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    if (!r_mem_we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                    w_dready_nxt  = 1'b1;
                    w_state_nxt   = RESP;
                end
            end
            RESP: begin
                // Requesters still show the completed request this cycle
                w_state_nxt = IDLE;
                w_flush_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign InstrF    = r_instr;
    assign IReadyF   = r_iready;
    assign ReadDataM = r_rdata;
    assign DReadyM   = r_dready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (LDR/STR) of the pipelined core.
- Runs a request/acknowledge FSM toward memory, arbitrates with data priority and bounded fetch starvation, and returns read data plus ready pulses.
- The hazard unit turns the ready pulses into StallF/StallM.
- Sits between the datapath's PCF/ALUOutM/WriteDataM nets and the external memory.

Parameters:
- STARVE_MAX, 4: number of consecutive lost arbitrations after which fetch wins the next grant (legal range 1..15).
- AW, 32: address width.
- DW, 32: data width.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
IReqF  in  1  fetch read request; held until IReadyF
PCF  in  AW  fetch address
IFlushF  in  1  discard the in-flight fetch response (branch taken)
InstrF  out  DW  fetched instruction, valid when IReadyF=1
IReadyF  out  1  one-cycle pulse: fetch transaction complete
DReqM  in  1  data request; held until DReadyM
MemWriteM  in  1  1=store, 0=load; sampled with DReqM
ALUOutM  in  AW  data address
WriteDataM  in  DW  store data
ReadDataM  out  DW  load data, valid when DReadyM=1
DReadyM  out  1  one-cycle pulse: data transaction complete
mem_req  out  1  memory request, registered, held until mem_ack
mem_we  out  1  memory write enable, registered
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion; ignored unless mem_req=1

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE; mem_req, mem_we, IReadyF, DReadyM = 0; mem_addr, mem_wdata, InstrF, ReadDataM, starve_cnt = 0.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present, arbitrate:
  - Winner D if DReqM=1 and (IReqF=0 or starve_cnt<STARVE_MAX); otherwise winner I.
  - On the edge: mem_req<=1. mem_addr<=PCF or ALUOutM. mem_we<=MemWriteM for D, 0 for I. mem_wdata<=WriteDataM for D stores.
  - Next state BUSY_I or BUSY_D.
- starve_cnt:
  - Increments when both request and D wins.
  - Clears when I wins.
  - Unchanged otherwise; never exceeds STARVE_MAX.
- BUSY_x without mem_ack: hold all mem_* outputs stable.
- BUSY_x with mem_ack:
  - mem_req<=0, mem_we<=0.
  - BUSY_I: InstrF<=mem_rdata. IReadyF<=1 unless the flush flag is set.
  - BUSY_D load: ReadDataM<=mem_rdata. BUSY_D store: ReadDataM holds. Either way DReadyM<=1.
  - Next state RESP.
- RESP: ready pulse is visible for exactly this cycle. No arbitration here, because requesters still show the old request. Next state IDLE; ready outputs clear.
- Latency: issue edge at T0 (IDLE), mem_req high from T1, ack at Tk (k≥1), ready high in cycle Tk+1, IDLE at Tk+2. Minimum back-to-back spacing is 3 cycles.
- IFlushF:
  - Sets an internal flush flag when asserted in BUSY_I, or in IDLE on the cycle I is granted.
  - The flag clears on leaving RESP.
  - A flushed fetch still completes on the memory side. InstrF updates, but IReadyF stays 0.
  - IFlushF in any other state has no effect.
- Requesters must hold request and address stable until their ready pulse. Dropping a request mid-transaction is illegal, except via reset or IFlushF.
- mem_ack while mem_req=0 is ignored.
- Reset mid-transaction: the FSM returns to IDLE and mem_req drops the next cycle. The memory must abandon the access. No ready pulse is generated.
- IReadyF and DReadyM are never both 1 in the same cycle.

Test Plan:
- Single load: DReqM=1, MemWriteM=0, ALUOutM=0x40. Memory acks 1 cycle after mem_req with 0xDEADBEEF. Then mem_addr=0x40, mem_we=0, DReadyM pulses exactly one cycle with ReadDataM=0xDEADBEEF, IReadyF stays 0.
- Store with 3-cycle latency: ALUOutM=0x80, WriteDataM=0x12345678. Then mem_we=1, mem_wdata=0x12345678, mem_addr stable for all 3 wait cycles; DReadyM pulses; ReadDataM keeps its old value.
- Starvation bound (STARVE_MAX=4): IReqF=1 and DReqM=1 continuously, each D ack immediate. Then grants are D,D,D,D,I,D,...; starve_cnt reads 4 before the I grant and 0 after it.
- Flush: fetch PCF=0x10 granted; IFlushF=1 during BUSY_I; ack with 0xE3A00001. Then IReadyF stays 0, RESP→IDLE occurs, and the next fetch (PCF=0x20) is served normally.
- Reset mid-transaction: reset=1 in BUSY_D with no ack. Then next cycle state=IDLE, mem_req=0, all outputs at reset values, no DReadyM pulse.
- Spurious ack: mem_ack=1 in IDLE and in RESP. Then there is no state change, no ready pulse, and InstrF/ReadDataM are unchanged.
